regfile_dump_reader: RTL and testbench

REGFILE_DUMP_READER -- requirements
Module: regfile_dump_reader

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_dump_reader_if.sv | 15 +
 rtl/lowest_set_finder.sv | 25 ++
 rtl/regfile_dump_reader.sv | 103 ++++++++++
 tb/tb_regfile_dump_reader.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and FSM state type for the register-file dump reader.
// The defaults describe a 64-bit, 32-entry architectural register file.
package regfile_pkg;
  localparam int XLEN       = 64;
  localparam int NREGS      = 32;
  localparam int REG_ADDR_W = $clog2(NREGS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } dumpState_t;
endpackage

// File: rtl/regfile_dump_reader_if.sv
// Output beat stream of the dump reader: one register (index, value, last flag) per handshake.
// The master drives the beat; the slave applies backpressure with out_ready.
interface regfile_dump_reader_if #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 5
);
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [XLEN-1:0]   out_data;
  logic              out_last;

  modport master (output out_valid, out_addr, out_data, out_last, input out_ready);
  modport slave  (input out_valid, out_addr, out_data, out_last, output out_ready);
endinterface

// File: rtl/lowest_set_finder.sv
// Picks the lowest set bit of a register mask, returning its index, its one-hot form,
// and whether any other (necessarily higher) bit remains set.
module lowest_set_finder #(
  parameter int NREGS = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic [NREGS-1:0] mask,
  output logic [AW-1:0]    lowIdx,
  output logic [NREGS-1:0] lowOneHot,
  output logic             anyHigher
);
  import regfile_pkg::*;

  // Two's-complement trick isolates the lowest set bit in one adder.
  assign lowOneHot = mask & (~mask + {{(NREGS-1){1'b0}}, 1'b1});
  assign anyHigher = |(mask & ~lowOneHot);

  for (genvar gi = 0; gi < AW; gi++) begin : gEncode
    logic [NREGS-1:0] sel;
    for (genvar gj = 0; gj < NREGS; gj++) begin : gSel
      assign sel[gj] = (((gj >> gi) & 1) == 1) ? lowOneHot[gj] : 1'b0;
    end
    assign lowIdx[gi] = |sel;
  end
endmodule

// File: rtl/regfile_dump_reader.sv
// Streams register-file contents out one beat per register, either the full file or only
// registers written since they were last dumped (tracked by snooping the write port).
module regfile_dump_reader #(
  parameter int XLEN  = regfile_pkg::XLEN,
  parameter int NREGS = regfile_pkg::NREGS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     dirty_only,
  input  logic                     wr_en,
  input  logic [$clog2(NREGS)-1:0] wr_addr,
  output logic [$clog2(NREGS)-1:0] rf_addr,
  input  logic [XLEN-1:0]          rf_data,
  regfile_dump_reader_if.master    outIf,
  output logic                     busy,
  output logic                     done
);
  import regfile_pkg::*;

  localparam int AW = $clog2(NREGS);

  dumpState_t       stateReg, stateNext;
  logic [NREGS-1:0] liveMask, liveNext;
  logic [NREGS-1:0] scanMask, scanNext;
  logic [NREGS-1:0] setVec, clrVec, lowOneHot;
  logic [AW-1:0]    lowIdx;
  logic             anyHigher;
  logic [AW-1:0]    outAddrReg, outAddrNext;
  logic [XLEN-1:0]  outDataReg, outDataNext;
  logic             outLastReg, outLastNext;

  lowest_set_finder #(.NREGS(NREGS)) uFinder (
    .mask      (scanMask),
    .lowIdx    (lowIdx),
    .lowOneHot (lowOneHot),
    .anyHigher (anyHigher)
  );

  // x0 is hardwired, so writes to it never mark anything dirty.
  for (genvar gi = 0; gi < NREGS; gi++) begin : gSnoop
    assign setVec[gi] = (gi != 0) && wr_en && (wr_addr == AW'(gi));
  end

  // A write landing on the same edge that reads the register must keep it dirty.
  assign liveNext = (liveMask & ~clrVec) | setVec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg   <= IDLE;
      liveMask   <= '0;
      scanMask   <= '0;
      outAddrReg <= '0;
      outDataReg <= '0;
      outLastReg <= 1'b0;
    end else begin
      stateReg   <= stateNext;
      liveMask   <= liveNext;
      scanMask   <= scanNext;
      outAddrReg <= outAddrNext;
      outDataReg <= outDataNext;
      outLastReg <= outLastNext;
    end
  end

  always_comb begin
    stateNext   = stateReg;
    scanNext    = scanMask;
    clrVec      = '0;
    outAddrNext = outAddrReg;
    outDataNext = outDataReg;
    outLastNext = outLastReg;
    case (stateReg)
      IDLE: begin
        if (start) begin
          scanNext  = dirty_only ? liveMask : '1;
          stateNext = (dirty_only && (liveMask == '0)) ? DONE : READ;
        end
      end
      READ: begin
        outAddrNext = lowIdx;
        outDataNext = rf_data;
        outLastNext = !anyHigher;
        scanNext    = scanMask & ~lowOneHot;
        clrVec      = lowOneHot;
        stateNext   = SEND;
      end
      SEND: begin
        if (outIf.out_ready) stateNext = outLastReg ? DONE : READ;
      end
      DONE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  assign rf_addr         = (stateReg == READ) ? lowIdx : '0;
  assign outIf.out_valid = (stateReg == SEND);
  assign outIf.out_addr  = outAddrReg;
  assign outIf.out_data  = outDataReg;
  assign outIf.out_last  = outLastReg;
  assign busy            = (stateReg != IDLE);
  assign done            = (stateReg == DONE);
endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader: a behavioural register file feeds rf_data,
// a negedge monitor records every handshake beat, and each task checks its own scenario.
module tb_regfile_dump_reader;
  typedef struct packed {
    logic [4:0]  addr;
    logic [63:0] data;
    logic        last;
    int          edgeNo;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n, start, dirty_only, wr_en, busy, done, rfClr;
  logic [4:0]  wr_addr, rf_addr;
  logic [63:0] rf_data, wrData;
  logic [63:0] rf [32];
  logic [63:0] expRf [32];
  int          cycle = 0;
  int          vectors = 0;
  int          miscompares = 0;
  int          doneCount = 0;
  int          doneEdge = -1;
  int          stallCycles = 0;
  beat_t       beats[$];
  logic        prevStall = 1'b0;
  logic [4:0]  prevAddr;
  logic [63:0] prevData;
  logic        prevLast;
  int          s;

  regfile_dump_reader_if #(.XLEN(64), .ADDR_W(5)) outIf ();

  regfile_dump_reader #(.XLEN(64), .NREGS(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dirty_only(dirty_only),
    .wr_en(wr_en), .wr_addr(wr_addr), .rf_addr(rf_addr), .rf_data(rf_data),
    .outIf(outIf), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  always @(posedge clk) begin
    if (rfClr) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wr_en && wr_addr != 5'd0) begin
      rf[wr_addr] <= wrData;
    end
  end
  assign rf_data = rf[rf_addr];

  // Beats are recorded mid-cycle; a valid&ready seen here completes at the next rising edge.
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      prevStall = 1'b0;
    end else begin
      if (prevStall) begin
        vectors++;
        if (outIf.out_valid !== 1'b1 || outIf.out_addr !== prevAddr ||
            outIf.out_data !== prevData || outIf.out_last !== prevLast) begin
          miscompares++;
          $display("FAIL stall_hold: valid %b addr %0d data %h last %b, required 1 %0d %h %b",
                   outIf.out_valid, outIf.out_addr, outIf.out_data, outIf.out_last,
                   prevAddr, prevData, prevLast);
        end
      end
      if (outIf.out_valid === 1'b1 && outIf.out_ready === 1'b1) begin
        beat_t b;
        b.addr = outIf.out_addr; b.data = outIf.out_data;
        b.last = outIf.out_last; b.edgeNo = cycle + 1;
        beats.push_back(b);
        $display("beat addr %0d data %h last %b edge %0d", b.addr, b.data, b.last, b.edgeNo);
      end
      if (outIf.out_valid === 1'b1 && outIf.out_ready !== 1'b1) stallCycles++;
      prevStall = (outIf.out_valid === 1'b1 && outIf.out_ready !== 1'b1);
      prevAddr  = outIf.out_addr;
      prevData  = outIf.out_data;
      prevLast  = outIf.out_last;
      if (done === 1'b1) begin
        doneCount++;
        doneEdge = cycle;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearLog();
    beats.delete();
    doneCount   = 0;
    doneEdge    = -1;
    stallCycles = 0;
  endtask

  task automatic doWrite(input logic [4:0] a, input logic [63:0] d);
    wr_en = 1'b1; wr_addr = a; wrData = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic doStart(input logic d, output int sampleEdge);
    start = 1'b1; dirty_only = d;
    sampleEdge = cycle + 1;
    tick();
    start = 1'b0; dirty_only = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    while (busy === 1'b1 && n < 300) begin
      tick();
      n++;
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_idle: busy %b after %0d cycles, required 0", tag, busy, n);
    end
  endtask

  task automatic waitBeat(input logic [4:0] a, input string tag);
    int n = 0;
    while (!(outIf.out_valid === 1'b1 && outIf.out_addr === a) && n < 300) begin
      tick();
      n++;
    end
    vectors++;
    if (!(outIf.out_valid === 1'b1 && outIf.out_addr === a)) begin
      miscompares++;
      $display("FAIL %s_wait: valid %b addr %0d, required 1 %0d", tag, outIf.out_valid, outIf.out_addr, a);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; dirty_only = 1'b0; wr_en = 1'b0;
    wr_addr = '0; wrData = '0; outIf.out_ready = 1'b1; rfClr = 1'b1;
    for (int i = 0; i < 32; i++) expRf[i] = '0;
    repeat (3) tick();
    vectors++;
    if ({outIf.out_valid, outIf.out_last, busy, done} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags: valid/last/busy/done %b, required 0000",
               {outIf.out_valid, outIf.out_last, busy, done});
    end
    vectors++;
    if (outIf.out_addr !== 5'd0 || outIf.out_data !== 64'd0 || rf_addr !== 5'd0) begin
      miscompares++;
      $display("FAIL reset_buses: addr %0d data %h rf_addr %0d, required 0 0 0",
               outIf.out_addr, outIf.out_data, rf_addr);
    end
    rfClr = 1'b0; rst_n = 1'b1;
    repeat (2) tick();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_no_start: busy %b, required 0", busy);
    end
  endtask

  task automatic test_full_dump();
    doWrite(5'd11, 64'd5); expRf[11] = 64'd5;
    doWrite(5'd28, 64'd1); expRf[28] = 64'd1;
    clearLog();
    doStart(1'b0, s);
    waitIdle("full");
    vectors++;
    if (beats.size() != 32) begin
      miscompares++;
      $display("FAIL full_count: %0d beats, required 32", beats.size());
    end
    for (int i = 0; i < beats.size() && i < 32; i++) begin
      vectors++;
      if (beats[i].addr !== 5'(i) || beats[i].data !== expRf[i] || beats[i].last !== (i == 31)) begin
        miscompares++;
        $display("FAIL full_beat%0d: addr %0d data %h last %b, required %0d %h %b",
                 i, beats[i].addr, beats[i].data, beats[i].last, i, expRf[i], i == 31);
      end
    end
    if (beats.size() == 32) begin
      vectors++;
      if (beats[0].edgeNo != s + 2 || beats[31].edgeNo != s + 64) begin
        miscompares++;
        $display("FAIL full_latency: first %0d last %0d, required %0d %0d",
                 beats[0].edgeNo - s, beats[31].edgeNo - s, 2, 64);
      end
    end
    vectors++;
    if (doneCount != 1 || doneEdge != s + 64) begin
      miscompares++;
      $display("FAIL full_done: count %0d edge %0d, required 1 %0d", doneCount, doneEdge - s, 64);
    end
  endtask

  task automatic test_dirty_only();
    doWrite(5'd5, 64'hAA); expRf[5] = 64'hAA;
    doWrite(5'd9, 64'hBB); expRf[9] = 64'hBB;
    clearLog();
    doStart(1'b1, s);
    waitIdle("dirty");
    vectors++;
    if (beats.size() != 2) begin
      miscompares++;
      $display("FAIL dirty_count: %0d beats, required 2", beats.size());
    end else begin
      vectors++;
      if (beats[0].addr !== 5'd5 || beats[0].data !== 64'hAA || beats[0].last !== 1'b0 ||
          beats[1].addr !== 5'd9 || beats[1].data !== 64'hBB || beats[1].last !== 1'b1) begin
        miscompares++;
        $display("FAIL dirty_beats: (%0d,%h,%b) (%0d,%h,%b), required (5,aa,0) (9,bb,1)",
                 beats[0].addr, beats[0].data, beats[0].last,
                 beats[1].addr, beats[1].data, beats[1].last);
      end
    end
    clearLog();
    doStart(1'b1, s);
    waitIdle("empty");
    vectors++;
    if (beats.size() != 0 || doneCount != 1 || doneEdge != s) begin
      miscompares++;
      $display("FAIL empty_dump: beats %0d done %0d edge %0d, required 0 1 0",
               beats.size(), doneCount, doneEdge - s);
    end
  endtask

  task automatic test_backpressure();
    clearLog();
    doStart(1'b0, s);
    waitBeat(5'd1, "bp");
    tick();
    outIf.out_ready = 1'b0;
    repeat (3) tick();
    vectors++;
    if (outIf.out_valid !== 1'b1 || outIf.out_addr !== 5'd2) begin
      miscompares++;
      $display("FAIL bp_held: valid %b addr %0d, required 1 2", outIf.out_valid, outIf.out_addr);
    end
    tick();
    outIf.out_ready = 1'b1;
    waitIdle("bp");
    vectors++;
    if (beats.size() != 32 || stallCycles != 3) begin
      miscompares++;
      $display("FAIL bp_count: beats %0d stalls %0d, required 32 3", beats.size(), stallCycles);
    end
    for (int i = 0; i < beats.size() && i < 32; i++) begin
      vectors++;
      if (beats[i].addr !== 5'(i) || beats[i].data !== expRf[i] || beats[i].last !== (i == 31)) begin
        miscompares++;
        $display("FAIL bp_beat%0d: addr %0d data %h last %b, required %0d %h %b",
                 i, beats[i].addr, beats[i].data, beats[i].last, i, expRf[i], i == 31);
      end
    end
    if (beats.size() == 32) begin
      vectors++;
      if (beats[31].edgeNo != s + 67) begin
        miscompares++;
        $display("FAIL bp_latency: last %0d, required 67", beats[31].edgeNo - s);
      end
    end
  endtask

  task automatic test_write_during_send();
    doWrite(5'd3, 64'h33); expRf[3] = 64'h33;
    clearLog();
    doStart(1'b1, s);
    outIf.out_ready = 1'b0;
    tick();
    doWrite(5'd3, 64'h77);
    outIf.out_ready = 1'b1;
    waitIdle("wsend");
    vectors++;
    if (beats.size() != 1 || beats[0].addr !== 5'd3 || beats[0].data !== 64'h33 || beats[0].last !== 1'b1) begin
      miscompares++;
      $display("FAIL wsend_old: beats %0d first (%0d,%h), required 1 (3,33)",
               beats.size(), beats[0].addr, beats[0].data);
    end
    expRf[3] = 64'h77;
    clearLog();
    doStart(1'b1, s);
    waitIdle("wsend2");
    vectors++;
    if (beats.size() != 1 || beats[0].addr !== 5'd3 || beats[0].data !== 64'h77 || beats[0].last !== 1'b1) begin
      miscompares++;
      $display("FAIL wsend_new: beats %0d first (%0d,%h), required 1 (3,77)",
               beats.size(), beats[0].addr, beats[0].data);
    end
  endtask

  task automatic test_set_wins();
    doWrite(5'd4, 64'h40); expRf[4] = 64'h40;
    clearLog();
    doStart(1'b1, s);
    doWrite(5'd4, 64'h44);
    waitIdle("setwin");
    vectors++;
    if (beats.size() != 1 || beats[0].addr !== 5'd4 || beats[0].data !== 64'h40) begin
      miscompares++;
      $display("FAIL setwin_capture: beats %0d first (%0d,%h), required 1 (4,40)",
               beats.size(), beats[0].addr, beats[0].data);
    end
    expRf[4] = 64'h44;
    clearLog();
    doStart(1'b1, s);
    waitIdle("setwin2");
    vectors++;
    if (beats.size() != 1 || beats[0].addr !== 5'd4 || beats[0].data !== 64'h44) begin
      miscompares++;
      $display("FAIL setwin_redirty: beats %0d first (%0d,%h), required 1 (4,44)",
               beats.size(), beats[0].addr, beats[0].data);
    end
  endtask

  task automatic test_reset_mid_dump();
    int nBefore;
    doWrite(5'd20, 64'h20); expRf[20] = 64'h20;
    clearLog();
    doStart(1'b0, s);
    waitBeat(5'd10, "rst");
    nBefore = beats.size();
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({outIf.out_valid, outIf.out_last, busy, done} !== 4'b0000 ||
        outIf.out_addr !== 5'd0 || outIf.out_data !== 64'd0 || rf_addr !== 5'd0) begin
      miscompares++;
      $display("FAIL rst_async: flags %b addr %0d data %h rf_addr %0d, required 0000 0 0 0",
               {outIf.out_valid, outIf.out_last, busy, done}, outIf.out_addr, outIf.out_data, rf_addr);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    vectors++;
    if (nBefore != 10 || beats.size() != 10 || doneCount != 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_abort: before %0d after %0d done %0d busy %b, required 10 10 0 0",
               nBefore, beats.size(), doneCount, busy);
    end
    clearLog();
    doStart(1'b1, s);
    waitIdle("rst_dirty");
    vectors++;
    if (beats.size() != 0 || doneCount != 1) begin
      miscompares++;
      $display("FAIL rst_live_clear: beats %0d done %0d, required 0 1", beats.size(), doneCount);
    end
    clearLog();
    doStart(1'b0, s);
    waitIdle("rst_full");
    vectors++;
    if (beats.size() != 32 || doneCount != 1) begin
      miscompares++;
      $display("FAIL rst_full_count: beats %0d done %0d, required 32 1", beats.size(), doneCount);
    end
    for (int i = 0; i < beats.size() && i < 32; i++) begin
      vectors++;
      if (beats[i].addr !== 5'(i) || beats[i].data !== expRf[i] || beats[i].last !== (i == 31)) begin
        miscompares++;
        $display("FAIL rst_beat%0d: addr %0d data %h last %b, required %0d %h %b",
                 i, beats[i].addr, beats[i].data, beats[i].last, i, expRf[i], i == 31);
      end
    end
  endtask

  task automatic test_start_busy_x0();
    doWrite(5'd0, 64'h99);
    clearLog();
    doStart(1'b1, s);
    waitIdle("x0");
    vectors++;
    if (beats.size() != 0 || doneCount != 1) begin
      miscompares++;
      $display("FAIL x0_dirty: beats %0d done %0d, required 0 1", beats.size(), doneCount);
    end
    clearLog();
    doStart(1'b0, s);
    waitBeat(5'd5, "busy");
    start = 1'b1; dirty_only = 1'b1;
    repeat (2) tick();
    start = 1'b0; dirty_only = 1'b0;
    waitIdle("busy");
    tick();
    vectors++;
    if (beats.size() != 32 || doneCount != 1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_start: beats %0d done %0d busy %b, required 32 1 0",
               beats.size(), doneCount, busy);
    end
    for (int i = 0; i < beats.size() && i < 32; i++) begin
      vectors++;
      if (beats[i].addr !== 5'(i) || beats[i].data !== expRf[i] || beats[i].last !== (i == 31)) begin
        miscompares++;
        $display("FAIL busy_beat%0d: addr %0d data %h last %b, required %0d %h %b",
                 i, beats[i].addr, beats[i].data, beats[i].last, i, expRf[i], i == 31);
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_full_dump();
    test_dirty_only();
    test_backpressure();
    test_write_during_send();
    test_set_wins();
    test_reset_mid_dump();
    test_start_busy_x0();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
